stage_id_reg: RTL



---
 rtl/rvcpu.sv | 70 +++++++
 rtl/decoder.sv | 72 +++++++
 rtl/gen_imm.sv | 29 ++
 rtl/id_scoreboard.sv | 40 ++++
 rtl/mux.sv | 13 +
 rtl/stage_id_reg.sv | 147 ++++++++++++++
 6 files changed

// File: rtl/rvcpu.sv
// Shared CPU types: program counter, instruction word, operand and register types,
// decode bundles, the ID stage payload and the ID stage state encoding.
package rvcpu;

    localparam int XLen    = 32;
    localparam int NumRegs = 32;
    localparam int RegBits = $clog2(NumRegs);

    typedef logic [31:0]        pc_t;
    typedef logic [31:0]        opcode_t;
    typedef logic [XLen-1:0]    data_t;
    typedef logic [RegBits-1:0] reg_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic is_wfi;
        logic illegal;
    } id_flags_t;

    typedef struct packed {
        alu_op_e   aluop;
        logic      rd_valid;
        logic      rs1_valid;
        logic      rs2_valid;
        imm_sel_e  imm_sel;
        id_flags_t flags;
    } decode_t;

    typedef struct packed {
        pc_t       pc;
        reg_t      rd;
        logic      rd_valid;
        alu_op_e   aluop;
        data_t     a;
        data_t     b;
        id_flags_t flags;
    } stage_id_t;

    typedef enum logic {RUN, WFI_WAIT} id_state_e;

    localparam opcode_t OpWfi = 32'h1050_0073;

    // funct3 plus the alternate bit (instr[30]) selects the ALU operation.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decoder.sv
// RV32I base decoder: turns an instruction word into ALU op, operand usage,
// immediate format and instruction class flags.
module decoder
    import rvcpu::*;
(
    input  opcode_t opcode,
    output decode_t dec
);

    // Classify the major opcode; unknown encodings are flagged illegal.
    always_comb begin
        dec         = '0;
        dec.aluop   = ALU_ADD;
        dec.imm_sel = IMM_I;
        case (opcode[6:0])
            7'b0010011: begin
                dec.rd_valid  = 1'b1;
                dec.rs1_valid = 1'b1;
                dec.aluop     = alu_from_funct(opcode[14:12], opcode[30] & (opcode[14:12] == 3'b101));
            end
            7'b0110011: begin
                dec.rd_valid  = 1'b1;
                dec.rs1_valid = 1'b1;
                dec.rs2_valid = 1'b1;
                dec.aluop     = alu_from_funct(opcode[14:12], opcode[30]);
            end
            7'b0110111: begin
                dec.rd_valid = 1'b1;
                dec.imm_sel  = IMM_U;
                dec.aluop    = ALU_PASSB;
            end
            7'b0010111: begin
                dec.rd_valid = 1'b1;
                dec.imm_sel  = IMM_U;
            end
            7'b0000011: begin
                dec.rd_valid      = 1'b1;
                dec.rs1_valid     = 1'b1;
                dec.flags.is_load = 1'b1;
            end
            7'b0100011: begin
                dec.rs1_valid      = 1'b1;
                dec.rs2_valid      = 1'b1;
                dec.imm_sel        = IMM_S;
                dec.flags.is_store = 1'b1;
            end
            7'b1100011: begin
                dec.rs1_valid       = 1'b1;
                dec.rs2_valid       = 1'b1;
                dec.imm_sel         = IMM_B;
                dec.aluop           = ALU_SUB;
                dec.flags.is_branch = 1'b1;
            end
            7'b1101111: begin
                dec.rd_valid      = 1'b1;
                dec.imm_sel       = IMM_J;
                dec.flags.is_jump = 1'b1;
            end
            7'b1100111: begin
                dec.rd_valid      = 1'b1;
                dec.rs1_valid     = 1'b1;
                dec.flags.is_jump = 1'b1;
            end
            7'b1110011: begin
                dec.flags.is_wfi  = (opcode == OpWfi);
                dec.flags.illegal = (opcode != OpWfi);
            end
            default: dec.flags.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/gen_imm.sv
// Immediate generator: assembles the sign-extended immediate for the selected format.
module gen_imm
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic [31:7]      instr_hi,
    input  imm_sel_e         imm_sel,
    output logic [Width-1:0] imm
);

    logic [31:0] imm32;

    // Reassemble the scattered immediate bits for each instruction format.
    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr_hi[31]}}, instr_hi[31:20]};
            IMM_S:   imm32 = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
            IMM_B:   imm32 = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};
            IMM_U:   imm32 = {instr_hi[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = Width'($signed(imm32));

endmodule

// File: rtl/id_scoreboard.sv
// Register busy scoreboard: one bit per architectural register marking an
// in-flight writer. x0 is never busy; a same-cycle set beats a clear.
module id_scoreboard #(
    parameter  int NumRegs = 32,
    localparam int RegBits = $clog2(NumRegs)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [RegBits-1:0] set_rd,
    input  logic               clr_en,
    input  logic [RegBits-1:0] clr_rd,
    input  logic [RegBits-1:0] rs1,
    input  logic [RegBits-1:0] rs2,
    output logic               rs1_busy,
    output logic               rs2_busy
);

    logic [NumRegs-1:0] busy_q;
    logic [NumRegs-1:0] busy_d;

    // Apply the retire clear first so a younger issuing writer to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // A writeback retiring this cycle already releases its register for the reader.
    assign rs1_busy = busy_q[rs1] & ~(clr_en & (clr_rd == rs1));
    assign rs2_busy = busy_q[rs2] & ~(clr_en & (clr_rd == rs2));

endmodule

// File: rtl/mux.sv
// Generic N-input one-hot-free multiplexer selected by a binary index.
module mux #(
    parameter int Inputs = 2,
    parameter int Width  = 32
) (
    input  logic [Inputs-1:0][Width-1:0] d,
    input  logic [$clog2(Inputs)-1:0]    sel,
    output logic [Width-1:0]             y
);

    assign y = d[sel];

endmodule

// File: rtl/stage_id_reg.sv
// Registered decode stage: decodes, selects operands, and holds the result in an
// output register with valid/ready on both sides, RAW stalls, flush and WFI parking.
module stage_id_reg
    import rvcpu::*;
#(
    parameter int Width   = 32,
    parameter int NumRegs = rvcpu::NumRegs
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  pc_t              pc,
    input  opcode_t          opcode,
    output reg_t             rs1,
    output reg_t             rs2,
    input  logic [Width-1:0] rs1_data,
    input  logic [Width-1:0] rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output stage_id_t        out,
    input  logic             wb_valid,
    input  reg_t             wb_rd,
    input  logic             flush,
    input  logic             wake
);

    id_state_e        state_q;
    id_state_e        state_d;
    stage_id_t        fresh;
    stage_id_t        out_d;
    logic             out_valid_d;
    decode_t          dec;
    logic [Width-1:0] imm;
    logic [Width-1:0] opa;
    logic [Width-1:0] opb;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             hazard;
    logic             in_fire;
    logic             out_fire;

    assign rs1 = opcode[19:15];
    assign rs2 = opcode[24:20];

    decoder u_decoder (
        .opcode (opcode),
        .dec    (dec)
    );

    gen_imm #(.Width(Width)) u_gen_imm (
        .instr_hi (opcode[31:7]),
        .imm_sel  (dec.imm_sel),
        .imm      (imm)
    );

    mux #(.Inputs(2), .Width(Width)) u_mux_a (
        .d   ({rs1_data, Width'(pc)}),
        .sel (dec.rs1_valid),
        .y   (opa)
    );

    mux #(.Inputs(2), .Width(Width)) u_mux_b (
        .d   ({rs2_data, imm}),
        .sel (dec.rs2_valid),
        .y   (opb)
    );

    assign out_fire = out_valid & out_ready;

    // The held instruction marks its destination busy only when EX actually takes it.
    id_scoreboard #(.NumRegs(NumRegs)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (out_fire & out.rd_valid & ~flush),
        .set_rd   (out.rd),
        .clr_en   (wb_valid),
        .clr_rd   (wb_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

    // A source conflicts with an issued writer or with the writer still sitting in out.
    always_comb begin
        rs1_hit = dec.rs1_valid & (rs1 != '0)
                & (rs1_busy | (out_valid & out.rd_valid & (out.rd == rs1)));
        rs2_hit = dec.rs2_valid & (rs2 != '0)
                & (rs2_busy | (out_valid & out.rd_valid & (out.rd == rs2)));
        hazard  = rs1_hit | rs2_hit;
    end

    assign in_ready = (state_q == RUN) & ~flush & ~hazard & (~out_valid | out_ready);
    assign in_fire  = in_valid & in_ready;

    // Assemble the payload that would be captured from the incoming instruction.
    always_comb begin
        fresh          = '0;
        fresh.pc       = pc;
        fresh.rd       = opcode[11:7];
        fresh.rd_valid = dec.rd_valid;
        fresh.aluop    = dec.aluop;
        fresh.a        = opa;
        fresh.b        = opb;
        fresh.flags    = dec.flags;
    end

    // Next output register contents and WFI state; flush overrides every other event.
    always_comb begin
        out_d       = out;
        out_valid_d = out_valid;
        state_d     = state_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = RUN;
        end else begin
            if (in_fire) begin
                out_d       = fresh;
                out_valid_d = 1'b1;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                RUN:      if (out_fire & out.flags.is_wfi & ~wake) state_d = WFI_WAIT;
                WFI_WAIT: if (wake) state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    // Output register and state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            out       <= out_d;
            out_valid <= out_valid_d;
        end
    end

endmodule
